// File: rtl/time_entry_pkg.sv
// time_entry_pkg: shared types and wrap arithmetic for the countdown preset entry block.
package time_entry_pkg;
    localparam int SEC_W = 6;
    typedef enum logic [1:0] {EDIT, REPEAT, LOCKED} state_t;
    function automatic logic [SEC_W-1:0] wrap_inc(input logic [SEC_W-1:0] v, input int max_sec);
        return (int'(v) >= max_sec) ? '0 : v + 1'b1;
    endfunction
    function automatic logic [SEC_W-1:0] wrap_dec(input logic [SEC_W-1:0] v, input int max_sec);
        return (v == '0) ? SEC_W'(max_sec) : v - 1'b1;
    endfunction
endpackage

// File: rtl/time_entry_if.sv
// time_entry_if: button, timer-status and preset/start signals between board, time_entry and countdown.
interface time_entry_if;
    import time_entry_pkg::*;
    logic             btn_up;
    logic             btn_down;
    logic             btn_go;
    logic             timer_busy;
    logic [SEC_W-1:0] seconds;
    logic             start;
    logic             editing;
    modport master (input btn_up, btn_down, btn_go, timer_busy, output seconds, start, editing);
    modport slave  (output btn_up, btn_down, btn_go, timer_busy, input seconds, start, editing);
endinterface

// File: rtl/time_entry_button_debouncer.sv
// button_debouncer: 2-FF synchronizer, stability counter and rise pulse for one raw pushbutton.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic restart_n,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic          raw;
    logic          armed;
    logic          level_q;
    logic [CW-1:0] cnt;
    // Synchronizer resets to "held" and armed stays low until a low sample is seen,
    // so a button held across reset never produces a press.
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            sync    <= 2'b11;
            raw     <= 1'b0;
            armed   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            if (!raw && !sync[1]) armed <= 1'b1;
            if (sync[1] == raw) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                raw <= sync[1];
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
    assign level = raw & armed;
    assign press = level & ~level_q;
endmodule

// File: rtl/time_entry.sv
// time_entry: debounced up/down/go preset editor driving the countdown seconds and start pulse.
// Optional auto-repeat on held up/down is enabled by defining TIME_ENTRY_AUTOREPEAT_EN.
module time_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int MAX_SECONDS     = 59
) (
    input  logic          clock,
    input  logic          restart_n,
    time_entry_if.master  bus
);
    import time_entry_pkg::*;
    logic [1:0]       rst_q;
    logic             rst_n_s;
    state_t           state, nxt;
    logic [SEC_W-1:0] sec;
    logic             up_l, up_p, dn_l, dn_p, go_p, unused_go;
    logic             fire, step_up, step_dn, inc, dec;
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) rst_q <= '0;
        else rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n_s = rst_q[1];
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (.clock(clock), .restart_n(rst_n_s), .btn(bus.btn_up), .level(up_l), .press(up_p));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (.clock(clock), .restart_n(rst_n_s), .btn(bus.btn_down), .level(dn_l), .press(dn_p));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go (.clock(clock), .restart_n(rst_n_s), .btn(bus.btn_go), .level(unused_go), .press(go_p));
    // A go press in an editable state blocks any up/down step in the same cycle.
    assign fire    = go_p && sec != '0 && state != LOCKED;
    assign step_up = state == EDIT && up_p && !dn_l && !go_p;
    assign step_dn = state == EDIT && dn_p && !up_l && !go_p;
`ifdef TIME_ENTRY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(RMAX + 1);
    logic [CW-1:0] cnt;
    logic          rpt_up, hold, tick;
    assign hold = rpt_up ? (up_l && !dn_l) : (dn_l && !up_l);
    assign tick = state == REPEAT && hold && !go_p && cnt == CW'(REPEAT_RATE - 1);
    assign inc  = step_up || (tick && rpt_up);
    assign dec  = step_dn || (tick && !rpt_up);
    // cnt counts clocks since the press while in EDIT, then clocks between steps in REPEAT.
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            cnt    <= '0;
            rpt_up <= 1'b0;
        end else if (step_up || step_dn) begin
            cnt    <= CW'(1);
            rpt_up <= step_up;
        end else if (nxt != state) cnt <= '0;
        else if (state == REPEAT) cnt <= (cnt == CW'(REPEAT_RATE - 1)) ? '0 : cnt + 1'b1;
        else if (state == EDIT && cnt != '0 && hold) cnt <= cnt + 1'b1;
        else cnt <= '0;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
    assign inc = step_up;
    assign dec = step_dn;
`endif
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) state <= EDIT;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        if (fire) nxt = LOCKED;
        else if (state == LOCKED) nxt = bus.timer_busy ? LOCKED : EDIT;
`ifdef TIME_ENTRY_AUTOREPEAT_EN
        else if (state == EDIT) nxt = (hold && cnt == CW'(REPEAT_DELAY - 1)) ? REPEAT : EDIT;
        else nxt = hold ? REPEAT : EDIT;
`endif
    end
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) sec <= '0;
        else if (inc) sec <= wrap_inc(sec, MAX_SECONDS);
        else if (dec) sec <= wrap_dec(sec, MAX_SECONDS);
    end
    always_comb begin
        bus.seconds = sec;
        bus.start   = fire;
        bus.editing = state != LOCKED;
    end
endmodule
